// File: rtl/chdr_xb_traffic_gen.sv
// Rate-shaped CHDR packet generator: header, timestamp and payload lines on
// an AXI-Stream master toward one crossbar input port.
module chdr_xb_traffic_gen #(
  parameter int          DWIDTH   = 64,
  parameter int          MTU_LOG2 = 7,
  parameter logic [15:0] SRC_ID   = 16'd0,
  parameter int          DEST_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [15:0]         cfg_num_pkts,
  input  logic [MTU_LOG2:0]   cfg_lpp,
  input  logic [6:0]          cfg_inj_rate,
  input  logic [DEST_W-1:0]   cfg_dest,
  output logic [DWIDTH-1:0]   m_axis_tdata,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                busy,
  output logic                done,
  output logic [15:0]         pkts_sent
);

  localparam int            LW      = MTU_LOG2 + 1;
  localparam logic [LW-1:0] MAX_LPP = LW'(2 ** MTU_LOG2);
  localparam logic [7:0]    FULL    = 8'd100;

  typedef enum logic [2:0] {IDLE, HDR, TS, PYLD, FIN} state_t;

  state_t            state_q, state_d;
  logic [63:0]       ts_cnt_q, ts_q, line_data;
  logic [15:0]       num_pkts_q, seq_q, pkts_q;
  logic [LW-1:0]     lpp_q, line_q, lpp_clamped;
  logic [6:0]        rate_q, rate_sane;
  logic [DEST_W-1:0] dest_q;
  logic [7:0]        acc_q, acc_d;
  logic              busy_q;
  logic              accept, active, valid, hs, last_line, more_pkts;

  assign accept    = (state_q == IDLE) && start;
  assign active    = state_q inside {HDR, TS, PYLD};
  assign valid     = active && (acc_q >= FULL);
  assign hs        = valid && m_axis_tready;
  assign last_line = (line_q == lpp_q - LW'(1));
  assign more_pkts = ({1'b0, pkts_q} + 17'd1) < {1'b0, num_pkts_q};

  always_comb begin
    lpp_clamped = cfg_lpp;
    if (cfg_lpp < LW'(2))
      lpp_clamped = LW'(2);
    else if (cfg_lpp > MAX_LPP)
      lpp_clamped = MAX_LPP;
    rate_sane = ((cfg_inj_rate == 7'd0) || (cfg_inj_rate > 7'd100)) ? 7'd100 : cfg_inj_rate;
  end

  // Credit accumulator: a line becomes eligible once 100 credits are banked;
  // credit only leaves on a handshake, so an offered line never retracts.
  always_comb begin
    acc_d = acc_q;
    if (active && ((acc_q < FULL) || hs))
      acc_d = acc_q + {1'b0, rate_q} - (hs ? FULL : 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (cfg_num_pkts == 16'd0) ? FIN : HDR;
      HDR:  if (hs) state_d = TS;
      TS, PYLD: begin
        if (hs) begin
          if (last_line)
            state_d = more_pkts ? HDR : FIN;
          else
            state_d = PYLD;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q   <= '0;
      ts_q       <= '0;
      num_pkts_q <= '0;
      lpp_q      <= LW'(2);
      rate_q     <= 7'd100;
      dest_q     <= '0;
      seq_q      <= '0;
      pkts_q     <= '0;
      acc_q      <= '0;
      line_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 64'd1;
      acc_q    <= acc_d;
      if (accept) begin
        num_pkts_q <= cfg_num_pkts;
        lpp_q      <= lpp_clamped;
        rate_q     <= rate_sane;
        dest_q     <= cfg_dest;
        seq_q      <= '0;
        pkts_q     <= '0;
        acc_q      <= '0;
        line_q     <= '0;
        busy_q     <= 1'b1;
      end else begin
        if (hs && (state_q == HDR))
          ts_q <= ts_cnt_q;
        if (hs) begin
          if (last_line) begin
            line_q <= '0;
            seq_q  <= seq_q + 16'd1;
            pkts_q <= pkts_q + 16'd1;
          end else begin
            line_q <= line_q + LW'(1);
          end
        end
        if (state_q == FIN)
          busy_q <= 1'b0;
      end
    end
  end

  always_comb begin
    line_data = '0;
    if (valid) begin
      case (state_q)
        HDR:     line_data = {SRC_ID, seq_q, 16'(lpp_q) << 3, 16'(dest_q)};
        TS:      line_data = ts_q;
        PYLD:    line_data = {seq_q, 16'd0, 32'(line_q)};
        default: line_data = '0;
      endcase
    end
    m_axis_tdata  = DWIDTH'(line_data);
    m_axis_tvalid = valid;
    m_axis_tlast  = valid && last_line;
    done          = (state_q == FIN);
    busy          = busy_q;
    pkts_sent     = pkts_q;
  end

endmodule

// File: tb/tb_chdr_xb_traffic_gen.sv
// Directed bench for chdr_xb_traffic_gen: a line-queue model built from the
// packet format rules is compared against every DUT beat.
module tb_chdr_xb_traffic_gen;

  localparam int          MTU_LOG2 = 7;
  localparam logic [15:0] SRC      = 16'hA5C3;

  logic        clk, rst_n, start, tready, tvalid, tlast, busy, done;
  logic [15:0] cfg_num_pkts, pkts_sent;
  logic [7:0]  cfg_lpp;
  logic [6:0]  cfg_inj_rate;
  logic [3:0]  cfg_dest;
  logic [63:0] tdata;

  chdr_xb_traffic_gen #(
    .DWIDTH(64), .MTU_LOG2(MTU_LOG2), .SRC_ID(SRC), .DEST_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_num_pkts(cfg_num_pkts), .cfg_lpp(cfg_lpp),
    .cfg_inj_rate(cfg_inj_rate), .cfg_dest(cfg_dest),
    .m_axis_tdata(tdata), .m_axis_tlast(tlast), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .busy(busy), .done(done), .pkts_sent(pkts_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          kind;   // 0 header, 1 timestamp, 2 payload
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] hs_cyc[$];
  logic [63:0] ts_vals[$];
  logic [63:0] ts_model, ts_at_hdr, exp_data, start_cyc, done_cyc, stall_data, hdr_tmp, first_beat;
  int checks, errors, valid_cycles, busy_cycles, done_cnt, beats;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Cycle number since reset release; equals the DUT timestamp counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_model <= '0;
    else        ts_model <= ts_model + 64'd1;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy) busy_cycles++;
        if (done) begin done_cnt++; done_cyc = ts_model; end
        if (tvalid) begin
          valid_cycles++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat actual=%h expected=none", tdata);
          end else begin
            exp_data = (exp_q[0].kind == 1) ? ts_at_hdr : exp_q[0].data;
            chk("beat_data", tdata, exp_data);
            chk("beat_last", 64'(tlast), 64'(exp_q[0].last));
            if (tready) begin
              if (exp_q[0].kind == 0) ts_at_hdr = ts_model;
              if (exp_q[0].kind == 1) ts_vals.push_back(tdata);
              if (beats == 0) first_beat = tdata;
              hs_cyc.push_back(ts_model);
              $display("beat cyc=%0d data=%h last=%b", ts_model, tdata, tlast);
              void'(exp_q.pop_front());
              beats++;
            end
          end
        end else begin
          chk("idle_tlast", 64'(tlast), 64'd0);
        end
      end
    end
  end

  task automatic gen_run(input int num, input int lpp_raw, input int dest);
    int    lpp;
    beat_t b;
    lpp = (lpp_raw < 2) ? 2 : ((lpp_raw > (1 << MTU_LOG2)) ? (1 << MTU_LOG2) : lpp_raw);
    for (int p = 0; p < num; p++) begin
      b.data = {SRC, 16'(p), 16'(lpp * 8), 16'(dest)}; b.last = 1'b0; b.kind = 0;
      exp_q.push_back(b);
      b.data = '0; b.last = (lpp == 2); b.kind = 1;
      exp_q.push_back(b);
      for (int i = 2; i < lpp; i++) begin
        b.data = {16'(p), 16'd0, 32'(i)}; b.last = (i == lpp - 1); b.kind = 2;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic do_start(input int num, input int lpp, input int rate, input int dest);
    hs_cyc.delete(); ts_vals.delete();
    valid_cycles = 0; busy_cycles = 0; done_cnt = 0; beats = 0;
    gen_run(num, lpp, dest);
    @(posedge clk); #1;
    cfg_num_pkts = 16'(num); cfg_lpp = 8'(lpp); cfg_inj_rate = 7'(rate); cfg_dest = 4'(dest);
    start = 1'b1;
    start_cyc = ts_model;
    @(posedge clk); #1;
    start = 1'b0;
    // Latched config must be immune to later changes.
    cfg_num_pkts = 16'd7; cfg_lpp = 8'd9; cfg_inj_rate = 7'd33; cfg_dest = 4'hF;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) break;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout actual=0 expected=1");
    end
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; beats = 0; done_cnt = 0;
    valid_cycles = 0; busy_cycles = 0; ts_at_hdr = '0; first_beat = '0;
    rst_n = 1'b1; start = 1'b0; tready = 1'b1;
    cfg_num_pkts = '0; cfg_lpp = '0; cfg_inj_rate = '0; cfg_dest = '0;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pkts", 64'(pkts_sent), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Three 4-line packets at full rate, with a stray start mid-run.
    do_start(3, 4, 100, 5);
    chk("model_hdr0", exp_q[0].data, 64'hA5C3_0000_0020_0005);
    chk("model_pyld3", exp_q[3].data, 64'h0000_0000_0000_0003);
    chk("model_last3", 64'(exp_q[3].last), 64'd1);
    chk("model_hdr1", exp_q[4].data, 64'hA5C3_0001_0020_0005);
    chk("model_hdr2", exp_q[8].data, 64'hA5C3_0002_0020_0005);
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(100);
    chk("a_beats", 64'(beats), 64'd12);
    if (hs_cyc.size() == 12) begin
      chk("a_first_beat", hs_cyc[0], start_cyc + 64'd2);
      for (int i = 1; i < 12; i++) chk("a_contig", hs_cyc[i] - hs_cyc[0], 64'(i));
      chk("a_done_cyc", done_cyc, hs_cyc[11] + 64'd1);
    end
    if (ts_vals.size() > 0) chk("a_ts_line", ts_vals[0], start_cyc + 64'd2);
    chk("a_pkts", 64'(pkts_sent), 64'd3);
    repeat (3) @(posedge clk);
    #1 chk("a_pkts_hold", 64'(pkts_sent), 64'd3);

    // Half rate, two 2-line packets.
    do_start(2, 2, 50, 0);
    wait_done(100);
    chk("b_beats", 64'(beats), 64'd4);
    chk("b_valid_cycles", 64'(valid_cycles), 64'd4);
    if (hs_cyc.size() == 4) begin
      chk("b_first_beat", hs_cyc[0], start_cyc + 64'd3);
      for (int i = 1; i < 4; i++) chk("b_spacing", hs_cyc[i] - hs_cyc[i-1], 64'd2);
    end

    // Backpressure for 10 cycles on payload line 2.
    do_start(1, 6, 100, 9);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (beats >= 2) break;
    end
    tready = 1'b0;
    stall_data = tdata;
    chk("c_stall_line", stall_data, 64'h0000_0000_0000_0002);
    repeat (10) begin
      @(negedge clk);
      chk("c_stall_valid", 64'(tvalid), 64'd1);
      chk("c_stall_data", tdata, stall_data);
    end
    @(posedge clk); #1 tready = 1'b1;
    wait_done(100);
    chk("c_beats", 64'(beats), 64'd6);

    // Zero packets: busy for one cycle, done pulse, no traffic.
    do_start(0, 4, 100, 1);
    wait_done(20);
    chk("d_valid_cycles", 64'(valid_cycles), 64'd0);
    chk("d_busy_cycles", 64'(busy_cycles), 64'd1);
    chk("d_done_cnt", 64'(done_cnt), 64'd1);

    // lpp 0 clamps to 2; rate 0 treated as full rate.
    do_start(2, 0, 0, 3);
    wait_done(100);
    chk("d_lpp0_beats", 64'(beats), 64'd4);
    if (hs_cyc.size() == 4)
      for (int i = 1; i < 4; i++) chk("d_rate0_contig", hs_cyc[i] - hs_cyc[i-1], 64'd1);

    // lpp 200 clamps to 128; rate above 100 treated as full rate.
    do_start(1, 200, 120, 2);
    hdr_tmp = exp_q[0].data;
    chk("model_len128", 64'(hdr_tmp[31:16]), 64'd1024);
    wait_done(400);
    chk("d_lpp200_beats", 64'(beats), 64'd128);
    if (hs_cyc.size() == 128) chk("d_lpp200_span", hs_cyc[127] - hs_cyc[0], 64'd127);

    // Reset mid-packet, then a fresh run.
    do_start(2, 8, 100, 4);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (beats >= 3) break;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("e_rst_tvalid", 64'(tvalid), 64'd0);
    chk("e_rst_busy", 64'(busy), 64'd0);
    chk("e_rst_tdata", tdata, 64'd0);
    chk("e_rst_pkts", 64'(pkts_sent), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_start(1, 3, 100, 6);
    wait_done(50);
    chk("e_beats", 64'(beats), 64'd3);
    chk("e_restart_hdr", first_beat, 64'hA5C3_0000_0018_0006);
    chk("e_pkts", 64'(pkts_sent), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
